// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encodings and a
// ceiling-log2 helper used to size counters from parameters.
package rr_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin picker: finds the first set request bit starting
// at ptr and wrapping past NUM_REQ-1 back to 0. Implemented by rotating a
// doubled request vector so ptr lands on bit 0, then a find-first-set.
module rr_arbiter_pick
    import rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               any,
    output logic [IDW-1:0]     idx,
    output logic [NUM_REQ-1:0] onehot
);

    localparam logic [IDW:0] NREQ = (IDW + 1)'(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [IDW-1:0]     off;
    logic [IDW:0]       sum;

    assign rot = NUM_REQ'({req, req} >> ptr);
    assign any = |rot;

    // Find the lowest set bit of the rotated vector (offset from ptr).
    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDW'(i);
            end
        end
    end

    // Map the offset back to an absolute requester index, modulo NUM_REQ.
    always_comb begin
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        idx    = sum[IDW-1:0];
        onehot = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, bounded hold time with
// preemption after MAX_HOLD cycles, and a forced one-cycle gap between owners.
// Optional build macro ARB_LOCK_EN adds a lock input that lets the current
// owner keep the grant past MAX_HOLD while it keeps requesting.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
`ifdef ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_id,
    output logic               busy,
    output logic               expired
);

    localparam int             HW       = clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

    logic [1:0]         state_q,   state_d;
    logic [NUM_REQ-1:0] gnt_q,     gnt_d;
    logic [IDW-1:0]     id_q,      id_d;
    logic [IDW-1:0]     ptr_q,     ptr_d;
    logic [HW-1:0]      hold_q,    hold_d;
    logic               expired_q, expired_d;

    logic               pick_any;
    logic [IDW-1:0]     pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               owner_req;
    logic               hold_lock;
    logic [IDW-1:0]     next_ptr;

    rr_arbiter_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .any     (pick_any),
        .idx     (pick_idx),
        .onehot  (pick_oh)
    );

`ifdef ARB_LOCK_EN
    assign hold_lock = lock;
`else
    assign hold_lock = 1'b0;
`endif

    assign owner_req = req[id_q];
    // The owner that just left becomes lowest priority on the next scan.
    assign next_ptr  = (id_q == LAST_ID) ? '0 : id_q + IDW'(1);

    // Next-state logic: arbitration in IDLE/GAP, hold tracking and exit in GRANT.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        expired_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_oh;
                    id_d    = pick_idx;
                    hold_d  = HW'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // A release on the expiry cycle wins, so expired only fires
                // when the owner is still requesting.
                if (!owner_req || (hold_q == HOLD_MAX && !hold_lock)) begin
                    state_d   = ST_GAP;
                    gnt_d     = '0;
                    id_d      = '0;
                    hold_d    = '0;
                    ptr_d     = next_ptr;
                    expired_d = owner_req;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                id_d    = '0;
                hold_d  = '0;
            end
        endcase
    end

    // State, grant and counter registers; async reset drops the grant at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            expired_q <= expired_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = id_q;
    assign busy    = |gnt_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (NUM_REQ=4, MAX_HOLD=8).
// The lock scenario is compiled only when ARB_LOCK_EN is defined.
module tb_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
`ifdef ARB_LOCK_EN
    logic       lock;
`endif
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       expired;

    // observed bundle: {gnt, gnt_id, busy, expired}
    logic [7:0] obs;
    logic [7:0] exp_v;
    int         n_checks;
    int         n_fail;

    assign obs = {gnt, gnt_id, busy, expired};

    rr_arbiter #(
        .NUM_REQ  (4),
        .MAX_HOLD (8),
        .IDW      (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
`ifdef ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .expired (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (obs !== 8'b0000_00_0_0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: gnt/id/busy/exp=%b required %b", i, obs, 8'b0000_00_0_0);
            end
        end
        reset = 1'b1;
        tick();
        exp_v = {4'b0001, 2'd0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release: gnt/id/busy/exp=%b required %b", obs, exp_v);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_single();
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = {4'b0100, 2'd2, 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL single_grant[%0d]: gnt/id/busy/exp=%b required %b", i, obs, exp_v);
            end
        end
        req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (obs !== 8'h00) begin
                n_fail++;
                $display("FAIL single_after[%0d]: gnt/id/busy/exp=%b required %b", i, obs, 8'h00);
            end
        end
    endtask

    task automatic test_rotation();
        int owner;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            owner = k % 4;
            for (int c = 0; c < 2; c++) begin
                tick();
                exp_v = {4'(1 << owner), 2'(owner), 1'b1, 1'b0};
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL rotation_grant[%0d.%0d]: gnt/id/busy/exp=%b required %b", k, c, obs, exp_v);
                end
            end
            req[owner] = 1'b0;
            tick();
            n_checks++;
            if (obs !== 8'h00) begin
                n_fail++;
                $display("FAIL rotation_gap[%0d]: gnt/id/busy/exp=%b required %b", k, obs, 8'h00);
            end
            if (k < 4) req[owner] = 1'b1;
            else       req = 4'b0000;
        end
        tick();
    endtask

    task automatic test_preempt();
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_v = {4'b0001, 2'd0, 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL preempt_own0[%0d]: gnt/id/busy/exp=%b required %b", i, obs, exp_v);
            end
        end
        tick();
        n_checks++;
        if (obs !== 8'b0000_00_0_1) begin
            n_fail++;
            $display("FAIL preempt_expire0: gnt/id/busy/exp=%b required %b", obs, 8'b0000_00_0_1);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_v = {4'b0010, 2'd1, 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL preempt_own1[%0d]: gnt/id/busy/exp=%b required %b", i, obs, exp_v);
            end
        end
        tick();
        n_checks++;
        if (obs !== 8'b0000_00_0_1) begin
            n_fail++;
            $display("FAIL preempt_expire1: gnt/id/busy/exp=%b required %b", obs, 8'b0000_00_0_1);
        end
        tick();
        exp_v = {4'b0001, 2'd0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL preempt_back0: gnt/id/busy/exp=%b required %b", obs, exp_v);
        end
        req = 4'b0000;
        tick();
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL preempt_release: gnt/id/busy/exp=%b required %b", obs, 8'h00);
        end
        tick();
    endtask

    task automatic test_release_at_max();
        req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_v = {4'b0100, 2'd2, 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL relmax_grant[%0d]: gnt/id/busy/exp=%b required %b", i, obs, exp_v);
            end
        end
        req = 4'b0000;
        tick();
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL relmax_no_expire: gnt/id/busy/exp=%b required %b", obs, 8'h00);
        end
        tick();
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        req  = 4'b0011;
        lock = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_v = {4'b0001, 2'd0, 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL lock_hold[%0d]: gnt/id/busy/exp=%b required %b", i, obs, exp_v);
            end
        end
        lock = 1'b0;
        tick();
        n_checks++;
        if (obs !== 8'b0000_00_0_1) begin
            n_fail++;
            $display("FAIL lock_drop_expire: gnt/id/busy/exp=%b required %b", obs, 8'b0000_00_0_1);
        end
        tick();
        exp_v = {4'b0010, 2'd1, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL lock_next_owner: gnt/id/busy/exp=%b required %b", obs, exp_v);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        tick();
        // pointer now sits at 2, so 1001 selects requester 3
        req = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = {4'b1000, 2'd3, 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL areset_pre[%0d]: gnt/id/busy/exp=%b required %b", i, obs, exp_v);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_immediate: gnt/id/busy/exp=%b required %b", obs, 8'h00);
        end
        #1;
        reset = 1'b1;
        tick();
        exp_v = {4'b0001, 2'd0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL areset_ptr_zero: gnt/id/busy/exp=%b required %b", obs, exp_v);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        req      = 4'b0000;
`ifdef ARB_LOCK_EN
        lock     = 1'b0;
`endif
        #2;
        reset = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_preempt();
        test_release_at_max();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
